// File: rtl/tetris_vga_renderer_if.sv
// Bundle between the game engine, the renderer and the VGA connector.
// master: the engine/board side. It drives the playfield state and observes the video outputs.
// slave : the renderer. It samples the playfield state and drives sync, colour, frame_start and the counters.
interface tetris_vga_renderer_if;
    logic [159:0] blocks;       // playfield bitmap, bit = row*8+col, row 0 bottom
    logic [7:0]   score;        // engine score
    logic [7:0]   location;     // pivot cell index of the active piece
    logic         q_Lose;       // engine LOSE flag
    logic         hSync;        // horizontal sync, active low
    logic         vSync;        // vertical sync, active low
    logic [7:0]   vgaRGB;       // pixel colour, RGB 3-3-2
    logic         frame_start;  // one-clock pulse on the snapshot cycle
    logic [9:0]   hCount;       // current pixel column
    logic [9:0]   vCount;       // current line

    modport master (
        output blocks, score, location, q_Lose,
        input  hSync, vSync, vgaRGB, frame_start, hCount, vCount
    );

    modport slave (
        input  blocks, score, location, q_Lose,
        output hSync, vSync, vgaRGB, frame_start, hCount, vCount
    );
endinterface

// File: rtl/tetris_vga_renderer.sv
// 640x480@60 Hz VGA renderer for the Tetris playfield, active-piece pivot, score lamps and lose border.
// The playfield state is latched into shadow registers once per frame, during vertical blank.
// Every displayed frame is therefore tear-free.
// Ports:
//   Clk   : system clock. One pixel lasts CLK_DIV clocks.
//   Reset : asynchronous, active-low reset.
//   bus   : slave side of tetris_vga_renderer_if. It carries the playfield inputs and the video outputs.
module tetris_vga_renderer #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned CELL_SIZE    = 16,
    parameter int unsigned BOARD_X0     = 256,
    parameter int unsigned BOARD_Y0     = 80,
    parameter logic [7:0]  COLOR_BG     = 8'h00,
    parameter logic [7:0]  COLOR_BLOCK  = 8'hFC,
    parameter logic [7:0]  COLOR_ACTIVE = 8'h1F,
    parameter logic [7:0]  COLOR_BORDER = 8'hFF,
    parameter logic [7:0]  COLOR_LOSE   = 8'hE0
) (
    input  logic Clk,
    input  logic Reset,
    tetris_vga_renderer_if.slave bus
);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CELL_SH = $clog2(CELL_SIZE);

    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] H_SYNC_S = 10'd656;
    localparam logic [9:0] H_SYNC_E = 10'd751;
    localparam logic [9:0] H_MAX    = 10'd799;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] V_SYNC_S = 10'd490;
    localparam logic [9:0] V_SYNC_E = 10'd491;
    localparam logic [9:0] V_MAX    = 10'd524;
    localparam logic [9:0] V_SNAP   = 10'd480;

    // Board rectangle, border ring and lamp strip. All upper bounds are exclusive.
    localparam logic [9:0] BX0 = 10'(BOARD_X0);
    localparam logic [9:0] BX1 = 10'(BOARD_X0 + 8 * CELL_SIZE);
    localparam logic [9:0] BY0 = 10'(BOARD_Y0);
    localparam logic [9:0] BY1 = 10'(BOARD_Y0 + 20 * CELL_SIZE);
    localparam logic [9:0] RX0 = 10'(BOARD_X0 - 4);
    localparam logic [9:0] RX1 = 10'(BOARD_X0 + 8 * CELL_SIZE + 4);
    localparam logic [9:0] RY0 = 10'(BOARD_Y0 - 4);
    localparam logic [9:0] RY1 = 10'(BOARD_Y0 + 20 * CELL_SIZE + 4);
    localparam logic [9:0] LY0 = 10'(BOARD_Y0 + 20 * CELL_SIZE + 8);
    localparam logic [9:0] LY1 = 10'(BOARD_Y0 + 20 * CELL_SIZE + 16);

    localparam logic [7:0] COLOR_LAMP_OFF = 8'h49;
    localparam logic [7:0] NUM_CELLS      = 8'd160;

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_hcount;
    logic [9:0]       r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic [7:0]       r_rgb;
    logic             r_frame_start;
    logic [159:0]     r_blocks;
    logic [7:0]       r_score;
    logic [7:0]       r_loc;
    logic             r_lose;

    logic             w_pix_en;
    logic             w_snap;
    logic             w_in_vis;
    logic             w_in_board;
    logic             w_in_ring;
    logic             w_in_lamp;
    logic [2:0]       w_col;
    logic [4:0]       w_row;
    logic [7:0]       w_idx;
    logic             w_bit;
    logic [7:0]       w_rgb;
    logic             w_hsync;
    logic             w_vsync;

    assign w_pix_en = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_snap   = w_pix_en && (r_hcount == '0) && (r_vcount == V_SNAP);

    // Pixel-rate divider
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Raster counters
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_pix_en) begin
            if (r_hcount == H_MAX) begin
                r_hcount <= '0;
                r_vcount <= (r_vcount == V_MAX) ? 10'd0 : r_vcount + 10'd1;
            end else begin
                r_hcount <= r_hcount + 10'd1;
            end
        end
    end

    // Vertical-blank snapshot of the engine state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_blocks <= '0;
            r_score  <= '0;
            r_loc    <= '0;
            r_lose   <= 1'b0;
        end else if (w_snap) begin
            r_blocks <= bus.blocks;
            r_score  <= bus.score;
            r_loc    <= bus.location;
            r_lose   <= bus.q_Lose;
        end
    end

    // Cell addressing. Rows count up from the bottom of the board.
    // The address is meaningful only inside the board.
    assign w_col = 3'((r_hcount - BX0) >> CELL_SH);
    assign w_row = 5'd19 - 5'((r_vcount - BY0) >> CELL_SH);
    assign w_idx = {w_row, w_col};
    // The range guard keeps the bitmap read in bounds for pixels outside the board.
    assign w_bit = (w_idx < NUM_CELLS) ? r_blocks[w_idx] : 1'b0;

    assign w_in_vis   = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign w_in_board = (r_hcount >= BX0) && (r_hcount < BX1) && (r_vcount >= BY0) && (r_vcount < BY1);
    assign w_in_ring  = (r_hcount >= RX0) && (r_hcount < RX1) && (r_vcount >= RY0) && (r_vcount < RY1)
                        && !w_in_board;
    assign w_in_lamp  = (r_hcount >= BX0) && (r_hcount < BX1) && (r_vcount >= LY0) && (r_vcount < LY1);

    // Pixel colour by render priority. The lamp index equals the cell column, and lamp 0 shows the score MSB.
    always_comb begin
        w_rgb = COLOR_BG;
        if (!w_in_vis) begin
            w_rgb = 8'h00;
        end else if (w_in_ring) begin
            w_rgb = r_lose ? COLOR_LOSE : COLOR_BORDER;
        end else if (w_in_board) begin
            if (w_bit) begin
                w_rgb = (w_idx == r_loc) ? COLOR_ACTIVE : COLOR_BLOCK;
            end
        end else if (w_in_lamp) begin
            w_rgb = r_score[3'd7 - w_col] ? COLOR_BORDER : COLOR_LAMP_OFF;
        end
    end

    assign w_hsync = !((r_hcount >= H_SYNC_S) && (r_hcount <= H_SYNC_E));
    assign w_vsync = !((r_vcount >= V_SYNC_S) && (r_vcount <= V_SYNC_E));

    // Video outputs. They are registered from the same counter values, so they lag the counters by one pixel.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_rgb         <= 8'h00;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_snap;
            if (w_pix_en) begin
                r_hsync <= w_hsync;
                r_vsync <= w_vsync;
                r_rgb   <= w_rgb;
            end
        end
    end

    assign bus.hSync       = r_hsync;
    assign bus.vSync       = r_vsync;
    assign bus.vgaRGB      = r_rgb;
    assign bus.frame_start = r_frame_start;
    assign bus.hCount      = r_hcount;
    assign bus.vCount      = r_vcount;

endmodule

// File: tb/tb_tetris_vga_renderer.sv
// Self-checking bench for tetris_vga_renderer.
// A reference model pushes the expected outputs for every pixel tick into a queue.
// A monitor pops one entry each time the DUT pixel counter moves and compares it with the DUT outputs.
// The monitor reports one comparison per line.
module tb_tetris_vga_renderer;
    localparam int unsigned DIV     = 2;
    localparam int unsigned H_TOT   = 800;
    localparam int unsigned V_TOT   = 525;
    localparam int unsigned FRAME   = H_TOT * V_TOT;
    localparam int unsigned RESET_K = 2 * FRAME + 200 * H_TOT + 300;

    typedef struct {
        int         h;
        int         v;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    tetris_vga_renderer_if bus ();

    tetris_vga_renderer #(.CLK_DIV(DIV)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    // ---------------- reference model ----------------
    int unsigned  m_clk;
    int unsigned  m_k;        // pixel ticks since reset release
    logic [159:0] s_blocks;
    logic [7:0]   s_score;
    logic [7:0]   s_loc;
    logic         s_lose;

    function automatic logic [7:0] ref_rgb(int x, int y);
        int col, row, idx, lamp;
        if (x >= 640 || y >= 480) return 8'h00;
        if (x >= 256 && x < 384 && y >= 80 && y < 400) begin
            col = (x - 256) / 16;
            row = 19 - (y - 80) / 16;
            idx = row * 8 + col;
            if (s_blocks[8'(idx)]) return (idx == int'(s_loc)) ? 8'h1F : 8'hFC;
            return 8'h00;
        end
        if (x >= 252 && x <= 387 && y >= 76 && y <= 403) return s_lose ? 8'hE0 : 8'hFF;
        if (y >= 408 && y <= 415 && x >= 256 && x <= 383) begin
            lamp = (x - 256) / 16;
            return s_score[3'(7 - lamp)] ? 8'hFF : 8'h49;
        end
        return 8'h00;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        int   px, py;
        exp_t e;
        if (!Reset) begin
            m_clk    = 0;
            m_k      = 0;
            s_blocks = '0;
            s_score  = '0;
            s_loc    = '0;
            s_lose   = 1'b0;
            q.delete();
        end else begin
            m_clk++;
            if (m_clk % DIV == 0) begin
                px    = int'(m_k % H_TOT);
                py    = int'((m_k / H_TOT) % V_TOT);
                e.rgb = ref_rgb(px, py);
                e.hs  = !(px >= 656 && px <= 751);
                e.vs  = !(py >= 490 && py <= 491);
                e.fs  = (px == 0 && py == 480);
                if (e.fs) begin
                    s_blocks = bus.blocks;
                    s_score  = bus.score;
                    s_loc    = bus.location;
                    s_lose   = bus.q_Lose;
                end
                m_k++;
                e.h = int'(m_k % H_TOT);
                e.v = int'((m_k / H_TOT) % V_TOT);
                q.push_back(e);
            end
        end
    end

    // ---------------- monitor ----------------
    int    last_h      = 0;
    int    line_no     = 0;
    int    line_pops   = 0;
    int    line_bad    = 0;
    string first_bad   = "";
    int    fs_seen     = 0;
    int    since_fs    = 0;
    int    hs_low      = 0;
    int    vs_low      = 0;
    int    per_pops    = 0;
    int    per_hs      = 0;
    int    per_vs      = 0;

    task automatic finish_line();
        checks++;
        if (line_bad != 0) begin
            failures++;
            $display("FAIL line_%0d: bad_pixels=%0d required 0; first %s", line_no, line_bad, first_bad);
        end
        line_no++;
        line_pops = 0;
        line_bad  = 0;
        first_bad = "";
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            if (line_pops > 0) finish_line();
            last_h = 0;
        end else if (int'(bus.hCount) != last_h) begin
            last_h = int'(bus.hCount);
            if (q.size() == 0) begin
                if (line_bad == 0) first_bad = $sformatf("counter moved with no expected tick at h=%0d", last_h);
                line_bad++;
            end else begin
                e = q.pop_front();
                if (int'(bus.hCount) != e.h || int'(bus.vCount) != e.v || bus.vgaRGB != e.rgb ||
                    bus.hSync != e.hs || bus.vSync != e.vs || bus.frame_start != e.fs) begin
                    if (line_bad == 0)
                        first_bad = $sformatf("got h=%0d v=%0d rgb=%h hs=%b vs=%b fs=%b, required h=%0d v=%0d rgb=%h hs=%b vs=%b fs=%b",
                                              bus.hCount, bus.vCount, bus.vgaRGB, bus.hSync, bus.vSync, bus.frame_start,
                                              e.h, e.v, e.rgb, e.hs, e.vs, e.fs);
                    line_bad++;
                end
            end
            if (bus.frame_start) begin
                if (fs_seen > 0) begin
                    per_pops = since_fs;
                    per_hs   = hs_low;
                    per_vs   = vs_low;
                end
                fs_seen++;
                since_fs = 0;
                hs_low   = 0;
                vs_low   = 0;
            end
            since_fs++;
            if (!bus.hSync) hs_low++;
            if (!bus.vSync) vs_low++;
            line_pops++;
            if (line_pops == int'(H_TOT)) finish_line();
        end else if (bus.frame_start) begin
            if (line_bad == 0) first_bad = $sformatf("frame_start high off the pixel tick at h=%0d", last_h);
            line_bad++;
        end
    end

    // ---------------- stimulus ----------------
    logic [159:0] set_blocks [3];
    logic [7:0]   set_score  [3];
    logic [7:0]   set_loc    [3];
    logic         set_lose   [3];

    function automatic logic [159:0] rand160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_random();
        bus.blocks   = rand160();
        bus.score    = 8'($urandom);
        bus.location = 8'($urandom);
        bus.q_Lose   = 1'($urandom);
    endtask

    task automatic check_eq(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        check_eq({tag, "_hCount"}, int'(bus.hCount), 0);
        check_eq({tag, "_vCount"}, int'(bus.vCount), 0);
        check_eq({tag, "_hSync"}, int'(bus.hSync), 1);
        check_eq({tag, "_vSync"}, int'(bus.vSync), 1);
        check_eq({tag, "_vgaRGB"}, int'(bus.vgaRGB), 0);
        check_eq({tag, "_frame_start"}, int'(bus.frame_start), 0);
    endtask

    initial begin
        int h, v, f;
        logic [159:0] b;

        // Set 0: sparse board with the corners, a highlighted pivot, score A5 and lose set.
        b = '0;
        b[0]   = 1'b1;
        b[159] = 1'b1;
        b[154] = 1'b1;
        set_blocks[0] = b;
        set_score[0]  = 8'hA5;
        set_loc[0]    = 8'd154;
        set_lose[0]   = 1'b1;
        // Set 1: random board with the pivot cell occupied and an out-of-range location.
        b = rand160();
        b[154] = 1'b1;
        set_blocks[1] = b;
        set_score[1]  = 8'($urandom);
        set_loc[1]    = 8'd200;
        set_lose[1]   = 1'b0;
        set_blocks[2] = rand160();
        set_score[2]  = 8'($urandom);
        set_loc[2]    = 8'($urandom_range(0, 159));
        set_lose[2]   = 1'b1;

        Reset = 1'b0;
        drive_random();
        repeat (3) @(negedge Clk);
        check_reset_outputs("init");
        #2 Reset = 1'b1;

        // Inputs hold garbage except around the snapshot line, so any sampling outside the snapshot shows up on screen.
        while (m_k != RESET_K) begin
            @(negedge Clk);
            #2;
            h = int'(m_k % H_TOT);
            v = int'((m_k / H_TOT) % V_TOT);
            f = int'(m_k / FRAME);
            if (f > 2) f = 2;
            if (v == 479 || v == 480) begin
                bus.blocks   = set_blocks[f];
                bus.score    = set_score[f];
                bus.location = set_loc[f];
                bus.q_Lose   = set_lose[f];
            end else if (h == 0) begin
                drive_random();
            end
        end

        // Mid-frame reset at hCount=300, vCount=200.
        check_eq("pre_reset_hCount", int'(bus.hCount), 300);
        check_eq("pre_reset_vCount", int'(bus.vCount), 200);
        Reset = 1'b0;
        #1 check_reset_outputs("midframe");
        repeat (3) @(negedge Clk);
        #2 Reset = 1'b1;

        while (m_k < 3 * H_TOT) begin
            @(negedge Clk);
            #2;
            if (h == 0) drive_random();
        end
        @(negedge Clk);
        #2;

        check_eq("backlog", q.size(), 0);
        check_eq("frame_start_count", fs_seen, 2);
        check_eq("frame_period_pixels", per_pops, int'(FRAME));
        check_eq("hsync_low_pixels_per_frame", per_hs, 525 * 96);
        check_eq("vsync_low_pixels_per_frame", per_vs, 2 * 800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tetris_vga_renderer.md
Name: tetris_vga_renderer

Overview:
Read-side counterpart of the Tetris game engine. It generates 640x480@60 Hz VGA timing and renders the engine's 8x20 playfield bitmap (blocks), the active-piece pivot cell (location), the score and the lose status. It sits between the game FSM outputs and the board's VGA connector. A vertical-blank snapshot keeps every displayed frame tear-free while the engine writes blocks.

Parameters:
CLK_DIV, 4, Clk cycles per pixel; pix_en is a 1-cycle pulse every CLK_DIV clocks (100 MHz -> 25 MHz).
CELL_SIZE, 16, cell edge in pixels; must be a power of 2.
BOARD_X0, 256, left pixel column of the playfield.
BOARD_Y0, 80, top pixel row of the playfield.
COLOR_BG, 8'h00, background colour, RGB 3-3-2.
COLOR_BLOCK, 8'hFC, occupied cell.
COLOR_ACTIVE, 8'h1F, pivot cell at snapshot location, when occupied.
COLOR_BORDER, 8'hFF, normal border and lit score lamps.
COLOR_LOSE, 8'hE0, border colour while lose is latched.

Ports:
Clk  in  1  system clock.
Reset  in  1  asynchronous, active-low reset.
blocks  in  160  playfield; bit = row*8+col, row 0 bottom, col 0 left.
score  in  8  engine score.
location  in  8  pivot cell index of the active piece.
q_Lose  in  1  engine LOSE state flag.
hSync  out  1  horizontal sync, active low.
vSync  out  1  vertical sync, active low.
vgaRGB  out  8  pixel colour, RGB 3-3-2.
frame_start  out  1  1-Clk pulse on the snapshot cycle.
hCount  out  10  current pixel column counter.
vCount  out  10  current line counter.

Behaviour:
- Reset low, asynchronous: divider, hCount and vCount = 0; hSync = vSync = 1; vgaRGB = 0; frame_start = 0; all shadow registers = 0. Reset mid-frame restarts at (0,0) after release.
- Divider counts 0..CLK_DIV-1 and asserts pix_en when it equals CLK_DIV-1. All counter and output updates occur only on pix_en.
- hCount runs 0..799 and wraps to 0. On that wrap, vCount increments and runs 0..524, wrapping to 0.
- Horizontal timing: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical timing: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Snapshot: on the pix_en where the counters read hCount=0 and vCount=480, latch blocks, score, location and q_Lose into shadow registers, and pulse frame_start for that one Clk. Inputs are ignored at all other times. Rendering uses only shadow values.
- Render priority, from the current counters (x=hCount, y=vCount):
  1. Outside the visible area: 0.
  2. Border: 4-px ring immediately outside the 128x320 board rectangle. Colour is COLOR_LOSE if shadow lose is set, else COLOR_BORDER.
  3. Board interior:
     - col = (x-BOARD_X0)/CELL_SIZE; row = 19-(y-BOARD_Y0)/CELL_SIZE; idx = row*8+col.
     - If shadow bit idx is set: COLOR_ACTIVE when idx == shadow location, else COLOR_BLOCK.
     - If the bit is clear: COLOR_BG.
  4. Score lamps: y in BOARD_Y0+328 .. BOARD_Y0+335; lamp i (0..7) spans x BOARD_X0+16i .. +15 and shows score bit 7-i (MSB left). Lit = COLOR_BORDER; unlit = 8'h49.
  5. Everything else: COLOR_BG.
- Division by CELL_SIZE is a shift.
- Location values >= 160 never match any cell, so no highlight is drawn. No out-of-range bitmap read is permitted.
- Latency: vgaRGB, hSync and vSync are registered on the same pix_en from the same counter values. They lag hCount/vCount by exactly one pixel and are mutually aligned.

Test Plan:
- Timing: run 2 frames from reset -> hSync low exactly 96 pixels per 800, vSync low exactly 2 lines per 525, 420000 pixel periods between frame_start pulses.
- Mapping: blocks = only bit 0 set -> COLOR_BLOCK exactly over x 256-271, y 384-399. Bit 159 only -> x 368-383, y 80-95. Every other board pixel = 8'h00.
- Snapshot: toggle blocks bit 80 while vCount=100 -> no change on screen this frame; change appears only after the next frame_start.
- Highlight: bit 154 set, location=154 -> COLOR_ACTIVE at x 288-303, y 80-95. With location=200 -> COLOR_BLOCK there.
- Score and lose: score=8'hA5, q_Lose=1 across a snapshot -> lamps 0, 2, 5, 7 lit and the rest 8'h49; border = 8'hE0.
- Reset mid-frame: assert Reset at hCount=300, vCount=200 -> all outputs take their reset values immediately; after release, counting resumes from (0,0) with correct timing.
